// File: rtl/nn_mac_pkg.sv
// Shared types, default parameters and the activation helper for the neuron MAC stage.
package nn_mac_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    localparam int DEF_N_INPUTS = 8;
    localparam int DEF_ACC_W    = 12;
    localparam int DEF_SHIFT    = 4;

    // Clamps the shifted sum to the next layer's 4-bit input range.
    function automatic logic [3:0] sat_act4(input logic hi_nonzero, input logic [3:0] lo);
        return hi_nonzero ? 4'hF : lo;
    endfunction

endpackage

// File: rtl/four_bit_multiplier.sv
// Unsigned 4x4 combinational multiplier feeding the MAC product register.
module four_bit_multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    assign p = 8'(a) * 8'(b);

endmodule

// File: rtl/neuron_mac_accumulator.sv
// Streaming multiply-accumulate for one neuron: registered products, bias add,
// full-width sum plus a saturated 4-bit activation for the next layer.
module neuron_mac_accumulator
    import nn_mac_pkg::*;
#(
    parameter int N_INPUTS = DEF_N_INPUTS,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int SHIFT    = DEF_SHIFT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_x,
    input  logic [3:0]       in_w,
    input  logic             in_last,
    input  logic [7:0]       bias,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [3:0]       out_act,
    output logic             err
);

    localparam int CNT_W = $clog2(N_INPUTS) + 1;

    state_t             state_q;
    logic [7:0]         prod_d;
    logic [7:0]         prod_q;
    logic               pv_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   prod_add;
    logic [ACC_W-1:0]   acc_final;
    logic [ACC_W-1:0]   shifted;
    logic [ACC_W-1:0]   out_acc_q;
    logic [3:0]         out_act_q;
    logic               err_q;
    logic               accept;
    logic               last_cnt;
    logic               terminate;

    four_bit_multiplier u_mult (
        .a (in_x),
        .b (in_w),
        .p (prod_d)
    );

    // Handshakes: a beat or result transfers on a rising edge where valid and
    // ready are both high; valid never depends on ready, and data is held while
    // valid waits. Input and output transfers never coexist.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_RESULT);
    assign accept    = in_valid && in_ready;
    assign last_cnt  = (cnt_q == CNT_W'(N_INPUTS - 1));
    assign terminate = accept && (in_last || last_cnt);

    // The terminating beat's product is still in prod_q during FLUSH.
    assign prod_add  = pv_q ? ACC_W'(prod_q) : '0;
    assign acc_final = acc_q + ACC_W'(prod_q) + ACC_W'(bias);
    assign shifted   = acc_final >> SHIFT;

    assign out_acc = out_acc_q;
    assign out_act = out_act_q;
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_ACCUM;
            acc_q     <= '0;
            prod_q    <= '0;
            pv_q      <= 1'b0;
            cnt_q     <= '0;
            out_acc_q <= '0;
            out_act_q <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    acc_q <= acc_q + prod_add;
                    if (accept) begin
                        prod_q <= prod_d;
                        pv_q   <= 1'b1;
                        cnt_q  <= cnt_q + 1'b1;
                    end else begin
                        pv_q <= 1'b0;
                    end
                    if (terminate) begin
                        state_q <= ST_FLUSH;
                        // Length is wrong when in_last and the N-th beat disagree.
                        if (in_last != last_cnt) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    out_acc_q <= acc_final;
                    out_act_q <= sat_act4(|(shifted >> 4), shifted[3:0]);
                    state_q   <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (out_ready) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        pv_q    <= 1'b0;
                        state_q <= ST_ACCUM;
                    end
                end
                default: begin
                    state_q <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Directed bench for neuron_mac_accumulator with hand-computed expected sums.
module tb_neuron_mac_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_x;
    logic [3:0]  in_w;
    logic        in_last;
    logic [7:0]  bias;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_acc;
    logic [3:0]  out_act;
    logic        err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] vx[8];
    logic [3:0] vw[8];

    neuron_mac_accumulator #(
        .N_INPUTS (8),
        .ACC_W    (12),
        .SHIFT    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_act   (out_act),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec(input int x_const, input int w_mode);
        for (int i = 0; i < 8; i++) begin
            vx[i] = 4'(x_const);
            vw[i] = (w_mode < 0) ? 4'(i + 1) : 4'(w_mode);
        end
    endtask

    // Sends n beats; in_last on the final beat when use_last is set.
    task automatic send_vector(input int n, input bit use_last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) tick();
            end
            in_valid = 1'b1;
            in_x     = vx[i];
            in_w     = vw[i];
            in_last  = use_last && (i == n - 1);
            check("beat_ready", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Called in cycle L+1; checks FLUSH, result at L+2, optional hold, handshake.
    task automatic expect_result(input int exp_acc, input int exp_act, input int exp_err,
                                 input int hold);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd0);
        tick();
        check("valid_l2", 32'(out_valid), 32'd1);
        check("out_acc", 32'(out_acc), 32'(exp_acc));
        check("out_act", 32'(out_act), 32'(exp_act));
        check("err", 32'(err), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            // Junk offered while not ready must be ignored.
            in_valid = 1'b1;
            in_x     = 4'hF;
            in_w     = 4'hF;
            in_last  = 1'b1;
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_acc", 32'(out_acc), 32'(exp_acc));
            check("hold_act", 32'(out_act), 32'(exp_act));
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        check("post_hs_ready", 32'(in_ready), 32'd1);
        check("post_hs_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_acc", 32'(out_acc), 32'd0);
        check("rst_act", 32'(out_act), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_last   = 1'b0;
        bias      = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check_reset_values();

        // x=1, w=1..8, back-to-back: 36, act 2
        load_vec(1, -1);
        bias = 8'd0;
        send_vector(8, 1'b1, 1'b0);
        expect_result(36, 2, 0, 0);

        // All 15x15 with bias 255: 1800+255=2055, act saturates
        load_vec(15, 15);
        bias = 8'd255;
        send_vector(8, 1'b1, 1'b0);
        expect_result(2055, 15, 0, 0);

        // Same as first vector with gaps and a 5-cycle output stall
        load_vec(1, -1);
        bias = 8'd0;
        send_vector(8, 1'b1, 1'b1);
        expect_result(36, 2, 0, 5);

        // Early in_last on beat 3: 3*6+10=28, act 1, length error
        load_vec(2, 3);
        bias = 8'd10;
        send_vector(3, 1'b1, 1'b0);
        expect_result(28, 1, 1, 0);

        // Clean vector afterwards: err stays sticky
        load_vec(1, -1);
        bias = 8'd0;
        send_vector(8, 1'b1, 1'b0);
        expect_result(36, 2, 1, 0);

        apply_reset();
        check_reset_values();

        // 8 beats without in_last: terminates on the 8th beat with err
        load_vec(1, 1);
        bias = 8'd0;
        send_vector(8, 1'b0, 1'b0);
        expect_result(8, 0, 1, 0);

        apply_reset();
        check_reset_values();

        // Reset after 4 beats discards the partial sum
        load_vec(15, 15);
        send_vector(4, 1'b0, 1'b0);
        apply_reset();
        check_reset_values();
        load_vec(1, -1);
        bias = 8'd0;
        send_vector(8, 1'b1, 1'b0);
        expect_result(36, 2, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
